decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/decode.sv | 135 +++++++++++++
 tb/tb_decode.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// decode: waits MEM_LAT cycles after decode_start, captures the instruction
// word from memory together with the fetch pc, and presents every
// instruction field at once.
// Optional feature: define DECODE_ILLEGAL_EN to raise illegal_out for the
// reserved opcode 4'b1101. Without it illegal_out is tied low.

module decode #(
    parameter int MEM_LAT = 1          // memory read latency, 1..4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        decode_start,
    input  logic [15:0] pc_in,
    input  logic [15:0] mem_dout,
    output logic [15:0] instr_out,
    output logic [3:0]  opCode_out,
    output logic [2:0]  dr_out,
    output logic [2:0]  sr1_out,
    output logic [2:0]  sr2_out,
    output logic [2:0]  br_nzp_out,
    output logic [8:0]  offset_out,
    output logic        imm_flag_out,
    output logic [15:0] imm5_out,
    output logic [15:0] offset6_out,
    output logic [15:0] pc_out,
    output logic        busy,
    output logic        decode_done,
    output logic        illegal_out
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    // Counter load value: the WAIT state lasts MEM_LAT cycles in total.
    localparam logic [1:0] LOAD_CNT = 2'(MEM_LAT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_cnt;
    logic [1:0]  w_next_cnt;
    logic        w_accept;
    logic        w_complete;
    logic [15:0] r_instr;
    logic [15:0] r_pc;
    logic        r_done;

    // Next-state logic: accept a start in IDLE, count down in WAIT, complete at zero.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                if (decode_start) begin
                    w_next_state = WAIT;
                    w_next_cnt   = LOAD_CNT;
                    w_accept     = 1'b1;
                end
            end
            WAIT: begin
                if (r_cnt != 2'd0) begin
                    w_next_cnt = r_cnt - 2'd1;
                end else begin
                    w_complete   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State and wait-counter registers; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Capture pc on accept, instruction word and done pulse on completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr <= 16'h0000;
            r_pc    <= 16'h0000;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_complete;
            if (w_accept) begin
                r_pc <= pc_in;
            end
            if (w_complete) begin
                r_instr <= mem_dout;
            end
        end
    end

`ifdef DECODE_ILLEGAL_EN
    logic r_illegal;

    // Reserved-opcode flag, refreshed only when a decode completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (w_complete) begin
            r_illegal <= (mem_dout[15:12] == 4'b1101);
        end
    end

    assign illegal_out = r_illegal;
`else
    assign illegal_out = 1'b0;
`endif

    // Fields are slices of the held instruction register, so they change
    // only on the completing edge and read as zero after reset.
    assign instr_out    = r_instr;
    assign opCode_out   = r_instr[15:12];
    assign dr_out       = r_instr[11:9];
    assign br_nzp_out   = r_instr[11:9];
    assign sr1_out      = r_instr[8:6];
    assign sr2_out      = r_instr[2:0];
    assign offset_out   = r_instr[8:0];
    assign imm_flag_out = r_instr[5];
    assign imm5_out     = {{11{r_instr[4]}}, r_instr[4:0]};
    assign offset6_out  = {{10{r_instr[5]}}, r_instr[5:0]};
    assign pc_out       = r_pc;
    assign busy         = (r_state == WAIT);
    assign decode_done  = r_done;

endmodule

// File: tb/tb_decode.sv
// tb_decode: drives two decode instances (MEM_LAT=1 and MEM_LAT=3) from a
// shared clock/reset; expected results are queued when a start is driven
// and compared when decode_done appears.

module tb_decode;

    typedef struct {
        bit          sel;      // 0: MEM_LAT=1 instance, 1: MEM_LAT=3 instance
        logic [15:0] pc;
        logic [15:0] word;
        logic [3:0]  op;
        logic [2:0]  dr;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic [2:0]  nzp;
        logic [8:0]  off9;
        logic        immf;
        logic [15:0] imm5;
        logic [15:0] off6;
        logic        ill;
    } vec_t;

    typedef struct {
        vec_t v;
        int   start_cyc;
    } exp_t;

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  op;
        logic [2:0]  dr;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic [2:0]  nzp;
        logic [8:0]  off9;
        logic        immf;
        logic [15:0] imm5;
        logic [15:0] off6;
        logic [15:0] pc;
        logic        busy;
        logic        done;
        logic        ill;
    } out_t;

`ifdef DECODE_ILLEGAL_EN
    localparam logic ILL_ON = 1'b1;
`else
    localparam logic ILL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    bit          cur_sel = 1'b0;
    logic [15:0] pc_in = 16'h0000;
    logic [15:0] mem_word = 16'h0000;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic start_1, start_3;
    assign start_1 = start && !cur_sel;
    assign start_3 = start && cur_sel;

    // Memory model: word is valid only in the cycle before it is sampled.
    logic [3:0]  mem_sr_1 = 4'd0;
    logic [3:0]  mem_sr_3 = 4'd0;
    logic [15:0] mem_dout_1, mem_dout_3;
    always @(posedge clk) begin
        mem_sr_1 <= {mem_sr_1[2:0], start_1};
        mem_sr_3 <= {mem_sr_3[2:0], start_3};
    end
    assign mem_dout_1 = mem_sr_1[0] ? mem_word : 16'hDEAD;
    assign mem_dout_3 = mem_sr_3[2] ? mem_word : 16'hDEAD;

    logic [15:0] instr_1, imm5_1, off6_1, pc_1, instr_3, imm5_3, off6_3, pc_3;
    logic [3:0]  op_1, op_3;
    logic [2:0]  dr_1, sr1_1, sr2_1, nzp_1, dr_3, sr1_3, sr2_3, nzp_3;
    logic [8:0]  off9_1, off9_3;
    logic        immf_1, busy_1, done_1, ill_1, immf_3, busy_3, done_3, ill_3;

    decode #(.MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .decode_start(start_1), .pc_in(pc_in),
        .mem_dout(mem_dout_1), .instr_out(instr_1), .opCode_out(op_1),
        .dr_out(dr_1), .sr1_out(sr1_1), .sr2_out(sr2_1), .br_nzp_out(nzp_1),
        .offset_out(off9_1), .imm_flag_out(immf_1), .imm5_out(imm5_1),
        .offset6_out(off6_1), .pc_out(pc_1), .busy(busy_1),
        .decode_done(done_1), .illegal_out(ill_1)
    );

    decode #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .decode_start(start_3), .pc_in(pc_in),
        .mem_dout(mem_dout_3), .instr_out(instr_3), .opCode_out(op_3),
        .dr_out(dr_3), .sr1_out(sr1_3), .sr2_out(sr2_3), .br_nzp_out(nzp_3),
        .offset_out(off9_3), .imm_flag_out(immf_3), .imm5_out(imm5_3),
        .offset6_out(off6_3), .pc_out(pc_3), .busy(busy_3),
        .decode_done(done_3), .illegal_out(ill_3)
    );

    out_t o1, o3;
    always_comb begin
        o1.instr = instr_1; o1.op = op_1; o1.dr = dr_1; o1.sr1 = sr1_1;
        o1.sr2 = sr2_1; o1.nzp = nzp_1; o1.off9 = off9_1; o1.immf = immf_1;
        o1.imm5 = imm5_1; o1.off6 = off6_1; o1.pc = pc_1; o1.busy = busy_1;
        o1.done = done_1; o1.ill = ill_1;
    end
    always_comb begin
        o3.instr = instr_3; o3.op = op_3; o3.dr = dr_3; o3.sr1 = sr1_3;
        o3.sr2 = sr2_3; o3.nzp = nzp_3; o3.off9 = off9_3; o3.immf = immf_3;
        o3.imm5 = imm5_3; o3.off6 = off6_3; o3.pc = pc_3; o3.busy = busy_3;
        o3.done = done_3; o3.ill = ill_3;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag, input out_t o);
        check({tag, "_instr"}, 32'(o.instr), 32'h0);
        check({tag, "_op"},    32'(o.op),    32'h0);
        check({tag, "_nzp"},   32'(o.nzp),   32'h0);
        check({tag, "_imm5"},  32'(o.imm5),  32'h0);
        check({tag, "_off6"},  32'(o.off6),  32'h0);
        check({tag, "_pc"},    32'(o.pc),    32'h0);
        check({tag, "_busy"},  32'(o.busy),  32'h0);
        check({tag, "_done"},  32'(o.done),  32'h0);
        check({tag, "_ill"},   32'(o.ill),   32'h0);
    endtask

    task automatic compare_done(input bit s, input out_t o);
        exp_t e;
        if (q.size() == 0 || q[0].v.sel != s) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: instance sel=%0d pulsed decode_done with no pending decode (cycle %0d)", s, cyc);
        end else begin
            e = q.pop_front();
            check("latency", 32'(cyc - e.start_cyc), s ? 32'd3 : 32'd1);
            check("instr",   32'(o.instr), 32'(e.v.word));
            check("op",      32'(o.op),    32'(e.v.op));
            check("dr",      32'(o.dr),    32'(e.v.dr));
            check("sr1",     32'(o.sr1),   32'(e.v.sr1));
            check("sr2",     32'(o.sr2),   32'(e.v.sr2));
            check("nzp",     32'(o.nzp),   32'(e.v.nzp));
            check("off9",    32'(o.off9),  32'(e.v.off9));
            check("immf",    32'(o.immf),  32'(e.v.immf));
            check("imm5",    32'(o.imm5),  32'(e.v.imm5));
            check("off6",    32'(o.off6),  32'(e.v.off6));
            check("pc",      32'(o.pc),    32'(e.v.pc));
            check("ill",     32'(o.ill),   32'(e.v.ill));
            check("busy_at_done", 32'(o.busy), 32'h0);
        end
    endtask

    // Scoreboard monitor: pops on every decode_done, flags double pulses.
    logic prev_done_1 = 1'b0;
    logic prev_done_3 = 1'b0;
    always @(negedge clk) begin
        if (o1.done) begin
            check("done_single_1", 32'(prev_done_1), 32'h0);
            compare_done(1'b0, o1);
        end
        if (o3.done) begin
            check("done_single_3", 32'(prev_done_3), 32'h0);
            compare_done(1'b1, o3);
        end
        prev_done_1 <= o1.done;
        prev_done_3 <= o3.done;
    end

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 12; i++) begin
            if (q.size() == 0) break;
            @(negedge clk); #1;
        end
        if (q.size() != 0) begin
            check({tag, "_timeout_pending"}, 32'(q.size()), 32'h0);
            q.delete();
        end
    endtask

    task automatic do_decode(input vec_t v);
        @(negedge clk);
        cur_sel  = v.sel;
        mem_word = v.word;
        pc_in    = v.pc;
        start    = 1'b1;
        q.push_back('{v, cyc + 1});
        @(negedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(v.sel ? o3.busy : o1.busy), 32'h1);
        wait_drain("decode");
    endtask

    // Hold start through the busy window with a different pc; only the
    // first request must complete and pc_out must stay at its pc.
    task automatic busy_ignore(input vec_t v, input logic [15:0] pc2, input int hold);
        @(negedge clk);
        cur_sel  = v.sel;
        mem_word = v.word;
        pc_in    = v.pc;
        start    = 1'b1;
        q.push_back('{v, cyc + 1});
        @(negedge clk);
        pc_in = pc2;
        repeat (hold - 1) @(negedge clk);
        start = 1'b0;
        wait_drain("busy_ignore");
        repeat (5) @(negedge clk);
        #1;
        check("ignored_pc_hold", 32'(v.sel ? o3.pc : o1.pc), 32'(v.pc));
        check("instr_hold",      32'(v.sel ? o3.instr : o1.instr), 32'(v.word));
        check("busy_idle",       32'(v.sel ? o3.busy : o1.busy), 32'h0);
    endtask

    vec_t vecs[8];
    vec_t va, vb;

    initial begin
        //          sel   pc        word      op    dr    sr1   sr2   nzp   off9    immf  imm5      off6      ill
        vecs[0] = '{1'b0, 16'h3001, 16'h12BD, 4'h1, 3'd1, 3'd2, 3'd5, 3'd1, 9'h0BD, 1'b1, 16'hFFFD, 16'hFFFD, 1'b0};
        vecs[1] = '{1'b0, 16'h3002, 16'h5705, 4'h5, 3'd3, 3'd4, 3'd5, 3'd3, 9'h105, 1'b0, 16'h0005, 16'h0005, 1'b0};
        vecs[2] = '{1'b1, 16'h3003, 16'h0DFF, 4'h0, 3'd6, 3'd7, 3'd7, 3'd6, 9'h1FF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[3] = '{1'b0, 16'h3004, 16'hD000, 4'hD, 3'd0, 3'd0, 3'd0, 3'd0, 9'h000, 1'b0, 16'h0000, 16'h0000, ILL_ON};
        vecs[4] = '{1'b0, 16'h3005, 16'h12BD, 4'h1, 3'd1, 3'd2, 3'd5, 3'd1, 9'h0BD, 1'b1, 16'hFFFD, 16'hFFFD, 1'b0};
        vecs[5] = '{1'b1, 16'h3006, 16'h0020, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 9'h020, 1'b1, 16'h0000, 16'hFFE0, 1'b0};
        vecs[6] = '{1'b1, 16'h3007, 16'hFFEF, 4'hF, 3'd7, 3'd7, 3'd7, 3'd7, 9'h1EF, 1'b1, 16'h000F, 16'hFFEF, 1'b0};
        vecs[7] = '{1'b0, 16'h3008, 16'h8010, 4'h8, 3'd0, 3'd0, 3'd0, 3'd0, 9'h010, 1'b0, 16'hFFF0, 16'h0010, 1'b0};

        // Reset for 5 cycles with no start: everything reads zero.
        repeat (5) @(negedge clk);
        #1;
        check_zero("reset1", o1);
        check_zero("reset3", o3);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("idle_busy1", 32'(o1.busy), 32'h0);

        // Table-driven decodes across both latencies.
        for (int i = 0; i < 8; i++) begin
            do_decode(vecs[i]);
        end

        // Starts during busy are dropped on both latencies.
        busy_ignore(vecs[1], 16'h4444, 2);
        va = vecs[2];
        va.pc = 16'h4100;
        busy_ignore(va, 16'h4555, 3);

        // Back-to-back: second start coincides with decode_done.
        va = vecs[0];
        va.pc = 16'h5001;
        vb = vecs[1];
        vb.pc = 16'h5002;
        @(negedge clk);
        cur_sel  = 1'b0;
        mem_word = va.word;
        pc_in    = va.pc;
        start    = 1'b1;
        q.push_back('{va, cyc + 1});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk); #1;
        check("b2b_first_done", 32'(o1.done), 32'h1);
        mem_word = vb.word;
        pc_in    = vb.pc;
        start    = 1'b1;
        q.push_back('{vb, cyc + 1});
        @(negedge clk); #1;
        start = 1'b0;
        check("b2b_second_busy", 32'(o1.busy), 32'h1);
        wait_drain("b2b");

        // Reset in the middle of a MEM_LAT=3 decode aborts it.
        @(negedge clk);
        cur_sel  = 1'b1;
        mem_word = 16'h0DFF;
        pc_in    = 16'h5555;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        #1;
        check_zero("abort3", o3);
        check_zero("abort1", o1);
        repeat (6) @(negedge clk);
        #1;
        check("abort_no_busy", 32'(o3.busy), 32'h0);
        check("abort_instr", 32'(o3.instr), 32'h0);

        // Restart after the abort completes normally.
        va = vecs[2];
        va.pc = 16'h5555;
        do_decode(va);

        repeat (4) @(negedge clk);
        check("queue_empty_end", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
